// File: rtl/gshare_bp.sv
//==============================================================================
// Module      : gshare_bp
// Description : Gshare direction predictor (PC xor GHR indexed 2-bit PHT)
//               with an IF->ID->EX copy of the fetch index and prediction.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module gshare_bp #(
    parameter int HIST_LEN = 10,
    parameter int IDX_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc_if,
    input  logic                stall,
    input  logic                flush,
    input  logic                update,
    input  logic                taken,
    input  logic [31:0]         pc_ex,
    output logic [IDX_W-1:0]    gpt_index,
    output logic                gshare_pred,
    output logic [IDX_W-1:0]    gpt_index_update,
    output logic                gshare_pred_ex,
    output logic [HIST_LEN-1:0] ghr
);

    localparam int         c_depth     = 2 ** IDX_W;
    localparam logic [1:0] c_strong_nt = 2'b00;
    localparam logic [1:0] c_weak_nt   = 2'b01;
    localparam logic [1:0] c_strong_t  = 2'b11;

    logic [1:0]          r_pht [c_depth];
    logic [HIST_LEN-1:0] r_ghr;
    logic [IDX_W-1:0]    r_id_idx;
    logic                r_id_pred;
    logic [IDX_W-1:0]    r_ex_idx;
    logic                r_ex_pred;

    logic [IDX_W-1:0]    w_if_idx;
    logic                w_if_pred;
    logic                w_train;
    logic [1:0]          w_ex_entry;
    logic [1:0]          w_ex_entry_next;
    logic                w_unused;

    // Fetch-side read: purely combinational, sees pre-write contents on a collision.
    assign w_if_idx  = pc_if[IDX_W+1:2] ^ r_ghr;
    assign w_if_pred = r_pht[w_if_idx][1];

    // Only word-aligned EX branches train the predictor.
    assign w_train    = update & (pc_ex[1:0] == 2'b00);
    assign w_ex_entry = r_pht[r_ex_idx];

    always_comb begin
        w_ex_entry_next = w_ex_entry;
        if (taken) begin
            if (w_ex_entry != c_strong_t)
                w_ex_entry_next = w_ex_entry + 2'b01;
        end else begin
            if (w_ex_entry != c_strong_nt)
                w_ex_entry_next = w_ex_entry - 2'b01;
        end
    end

    // PHT lives in flops so that every entry can return to weak-not-taken on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++)
                r_pht[i] <= c_weak_nt;
        end else if (w_train) begin
            r_pht[r_ex_idx] <= w_ex_entry_next;
        end
    end

    // History is non-speculative: it only shifts when a branch resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ghr <= '0;
        else if (w_train)
            r_ghr <= {r_ghr[HIST_LEN-2:0], taken};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_idx  <= '0;
            r_id_pred <= 1'b0;
            r_ex_idx  <= '0;
            r_ex_pred <= 1'b0;
        end else if (flush) begin
            r_id_idx  <= '0;
            r_id_pred <= 1'b0;
            r_ex_idx  <= '0;
            r_ex_pred <= 1'b0;
        end else if (!stall) begin
            r_id_idx  <= w_if_idx;
            r_id_pred <= w_if_pred;
            r_ex_idx  <= r_id_idx;
            r_ex_pred <= r_id_pred;
        end
    end

    assign gpt_index        = w_if_idx;
    assign gshare_pred      = w_if_pred;
    assign gpt_index_update = r_ex_idx;
    assign gshare_pred_ex   = r_ex_pred;
    assign ghr              = r_ghr;

    // PC bits outside the index field and the EX PC above the alignment bits are don't-care.
    assign w_unused = ^{pc_if[31:IDX_W+2], pc_if[1:0], pc_ex[31:2]};

endmodule

`default_nettype wire

// File: tb/tb_gshare_bp.sv
//==============================================================================
// Module      : tb_gshare_bp
// Description : Directed self-checking bench for gshare_bp.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gshare_bp;

    localparam int HIST_LEN = 10;
    localparam int IDX_W    = 10;

    logic                clk;
    logic                rst;
    logic [31:0]         pc_if;
    logic                stall;
    logic                flush;
    logic                update;
    logic                taken;
    logic [31:0]         pc_ex;
    logic [IDX_W-1:0]    gpt_index;
    logic                gshare_pred;
    logic [IDX_W-1:0]    gpt_index_update;
    logic                gshare_pred_ex;
    logic [HIST_LEN-1:0] ghr;

    int                  n_checks;
    int                  n_fail;
    logic [HIST_LEN-1:0] m_ghr;

    gshare_bp #(
        .HIST_LEN (HIST_LEN),
        .IDX_W    (IDX_W)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .pc_if            (pc_if),
        .stall            (stall),
        .flush            (flush),
        .update           (update),
        .taken            (taken),
        .pc_ex            (pc_ex),
        .gpt_index        (gpt_index),
        .gshare_pred      (gshare_pred),
        .gpt_index_update (gpt_index_update),
        .gshare_pred_ex   (gshare_pred_ex),
        .ghr              (ghr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_for(input logic [IDX_W-1:0] idx, input logic [HIST_LEN-1:0] g);
        return {20'h0, idx ^ g, 2'b00};
    endfunction

    task automatic train(input logic t, input logic [31:0] pcx);
        update = 1'b1;
        taken  = t;
        pc_ex  = pcx;
        tick();
        update = 1'b0;
        if (pcx[1:0] == 2'b00)
            m_ghr = {m_ghr[HIST_LEN-2:0], t};
    endtask

    task automatic probe(input string tag, input logic [IDX_W-1:0] idx, input logic exp_pred);
        pc_if = pc_for(idx, m_ghr);
        #1;
        check({tag, "_idx"}, 32'(gpt_index), 32'(idx));
        check({tag, "_pred"}, 32'(gshare_pred), 32'(exp_pred));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_ghr    = '0;
        rst      = 1'b1;
        pc_if    = 32'h0000_0100;
        stall    = 1'b0;
        flush    = 1'b0;
        update   = 1'b0;
        taken    = 1'b0;
        pc_ex    = 32'h0;

        // Reset state
        #2;
        check("rst_gpt_index", 32'(gpt_index), 32'h040);
        check("rst_pred", 32'(gshare_pred), 32'h0);
        check("rst_ghr", 32'(ghr), 32'h0);
        check("rst_idx_upd", 32'(gpt_index_update), 32'h0);
        check("rst_pred_ex", 32'(gshare_pred_ex), 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Fetch index reaches EX after two edges
        tick();
        check("pipe_1edge", 32'(gpt_index_update), 32'h0);
        tick();
        check("pipe_2edge", 32'(gpt_index_update), 32'h040);

        // Train taken at 0x040 with EX held by stall, then redirect fetch
        stall = 1'b1;
        train(1'b1, 32'h0000_0100);
        check("train_ghr", 32'(ghr), 32'h001);
        check("train_ex_held", 32'(gpt_index_update), 32'h040);
        pc_if = 32'h0000_0104;
        #1;
        check("redirect_idx", 32'(gpt_index), 32'h040);
        check("redirect_pred", 32'(gshare_pred), 32'h1);

        // Saturation at strong taken, then walk back down
        for (int i = 0; i < 3; i++)
            train(1'b1, 32'h0000_0100);
        check("sat_ghr", 32'(ghr), 32'h00F);
        probe("sat_11", 10'h040, 1'b1);
        train(1'b0, 32'h0000_0100);
        probe("dec_10", 10'h040, 1'b1);
        train(1'b0, 32'h0000_0100);
        check("dec_ghr", 32'(ghr), 32'h03C);
        probe("dec_01", 10'h040, 1'b0);
        train(1'b1, 32'h0000_0100);
        probe("inc_10", 10'h040, 1'b1);

        // Pipeline A,B,C without stall
        stall = 1'b0;
        pc_if = pc_for(10'h123, m_ghr);
        tick();
        pc_if = pc_for(10'h2AA, m_ghr);
        tick();
        check("pipe_a_idx", 32'(gpt_index_update), 32'h123);
        check("pipe_a_pred", 32'(gshare_pred_ex), 32'h0);
        pc_if = pc_for(10'h040, m_ghr);
        tick();
        check("pipe_b_idx", 32'(gpt_index_update), 32'h2AA);
        tick();
        check("pipe_c_idx", 32'(gpt_index_update), 32'h040);
        check("pipe_c_pred", 32'(gshare_pred_ex), 32'h1);

        // Stall holds EX while fetch moves on
        stall = 1'b1;
        pc_if = pc_for(10'h123, m_ghr);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_idx", 32'(gpt_index_update), 32'h040);
            check("stall_pred", 32'(gshare_pred_ex), 32'h1);
        end

        // Flush beats stall; same-cycle update trains pre-flush index 0x040
        flush = 1'b1;
        train(1'b0, 32'h0000_0200);
        flush = 1'b0;
        check("flush_idx", 32'(gpt_index_update), 32'h0);
        check("flush_pred_ex", 32'(gshare_pred_ex), 32'h0);
        check("flush_ghr", 32'(ghr), 32'h0F2);
        probe("flush_trained", 10'h040, 1'b0);

        // Misaligned EX PC changes nothing
        train(1'b1, 32'h0000_0102);
        check("misalign_ghr", 32'(ghr), 32'h0F2);
        probe("misalign_pht", 10'h000, 1'b0);

        // GHR fills with ones after enough taken updates
        for (int i = 0; i < 11; i++)
            train(1'b1, 32'h0000_0100);
        check("wrap_ghr", 32'(ghr), 32'h3FF);
        probe("wrap_pht0", 10'h000, 1'b1);

        // Asynchronous reset in mid-cycle
        stall = 1'b0;
        pc_if = pc_for(10'h155, m_ghr);
        tick();
        tick();
        check("pre_rst_idx", 32'(gpt_index_update), 32'h155);
        #2;
        rst = 1'b1;
        #1;
        m_ghr = '0;
        check("async_rst_idx", 32'(gpt_index_update), 32'h0);
        check("async_rst_ghr", 32'(ghr), 32'h0);
        probe("async_rst_pht0", 10'h000, 1'b0);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gshare_bp.md
# gshare_bp

Gshare direction predictor feeding the tournament chooser table. In IF it XORs the fetch PC with a global history register (GHR) to index a pattern history table (PHT) of 2-bit saturating counters, and produces the Gshare prediction. It carries the fetch-time index and prediction down to EX so the chooser and the PHT are trained with the same index used at fetch. It owns the PHT, the GHR and the IF→ID→EX index pipeline.

## Interface
- HIST_LEN, 10, GHR width in bits.
- IDX_W, 10, PHT index width; must equal HIST_LEN; PHT depth is 2**IDX_W.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- pc_if  in  32  fetch PC.
- stall  in  1  holds the ID and EX pipeline registers.
- flush  in  1  squashes the ID and EX pipeline registers; has priority over stall.
- update  in  1  branch resolved in EX; one-cycle pulse per branch.
- taken  in  1  resolved outcome of the EX branch.
- pc_ex  in  32  EX-stage PC; used only for the alignment qualifier.
- gpt_index  out  IDX_W  IF index = pc_if[IDX_W+1:2] ^ ghr; combinational.
- gshare_pred  out  1  IF prediction = PHT[gpt_index][1]; combinational.
- gpt_index_update  out  IDX_W  EX-stage copy of the fetch index; registered.
- gshare_pred_ex  out  1  EX-stage copy of the fetch prediction; registered.
- ghr  out  HIST_LEN  current global history; registered.

## Operation
- PHT entry encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. The prediction is the entry's MSB.
- Pipeline registers: id_idx/id_pred and ex_idx/ex_pred. gpt_index_update = ex_idx, gshare_pred_ex = ex_pred.
- Each posedge, in priority order:
  - flush: id_* and ex_* load 0.
  - else stall: id_* and ex_* hold.
  - else id_* ← {gpt_index, gshare_pred}, and ex_* ← id_*.
- Training is qualified by q = update & (pc_ex[1:0] == 2'b00). On a posedge with q:
  - PHT[ex_idx]: if taken and entry ≠ 11, increment; if not taken and entry ≠ 00, decrement; otherwise hold.
  - ghr ← {ghr[HIST_LEN-2:0], taken}. The GHR is non-speculative and is updated only at resolve.
- If q is 0, the PHT and GHR hold. A misaligned pc_ex with update high changes nothing.
- stall and flush do not gate training. A q cycle always trains exactly once.
- Training uses ex_idx, never an index recomputed from pc_ex.

## Timing
- Reset values:
  - All PHT entries = 01.
  - ghr = 0.
  - id_*, ex_* = 0, so gpt_index_update = 0 and gshare_pred_ex = 0.
  - gpt_index = pc_if[IDX_W+1:2] and gshare_pred = 0 immediately after reset.
- Read is combinational in the same cycle as pc_if. The index reaches gpt_index_update 2 posedges later when there is no stall or flush.
- Outputs change only after posedge and are stable through negedge, so the chooser samples them on negedge.
- Read/write to the same entry in the same cycle: IF sees the old value that cycle and the new value after the posedge.
- Simultaneous update and flush: the PHT/GHR train using the pre-flush ex_idx, and ex_* clear in the same posedge.
- GHR wrap-around: the oldest bit is discarded, and after HIST_LEN taken updates ghr is all ones.
- rst asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. An update in flight is lost.

## Test plan
- Reset: assert rst, pc_if=0x0000_0100 → gpt_index=0x040, gshare_pred=0, ghr=0, gpt_index_update=0, gshare_pred_ex=0.
- Train and redirect: let ex_idx=0x040; update=1, taken=1, pc_ex=0x100 for one cycle → PHT[0x040]=10, ghr=0x001; then pc_if=0x104 → gpt_index=0x040, gshare_pred=1.
- Saturation: three more taken updates at ex_idx=0x040 → the entry stays 11. Then one not-taken update → entry 10, gshare_pred stays 1. Then one more not-taken → entry 01, gshare_pred=0.
- Pipeline and stall:
  - pc_if=A,B,C on successive cycles, no stall → gpt_index_update equals idx(A) 2 posedges after A was presented.
  - Assert stall for 3 cycles → gpt_index_update and gshare_pred_ex hold constant.
- Flush priority: with stall=1 and flush=1 together → next posedge gpt_index_update=0 and gshare_pred_ex=0. An update=1 in that same cycle still trains the pre-flush ex_idx.
- Misaligned and GHR wrap:
  - update=1 with pc_ex=0x102 → PHT and ghr unchanged.
  - 11 consecutive taken aligned updates from ghr=0 → ghr=0x3FF.
